// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control FSM for a tiny 8-bit accumulator-style RISC core.
// It fetches byte instructions, drives an external ALU and owns four 8-bit registers.
module risc_ctrl_fsm #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic       instr_req,
    output logic [7:0] instr_addr,
    input  logic       instr_ack,
    input  logic [7:0] instr_data,
    output logic [2:0] alu_control,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       wb_valid,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_IMM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] result;
    logic [7:0] regs [0:3];

    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       is_alu_op;
    logic       unused_ir_bit;

    assign opcode        = ir[7:5];
    assign rd            = ir[4:3];
    assign rs            = ir[2:1];
    assign unused_ir_bit = ir[0];
    assign is_alu_op     = (opcode <= OP_NOT);

    always_comb begin
        // NOTE: default assignment first, so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_FETCH: begin
                if (instr_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu_op)                                  state_next = S_EXEC;
                else if (opcode == OP_LDI || opcode == OP_JMP)  state_next = S_IMM;
                else                                            state_next = S_HALT;
            end
            S_EXEC:  state_next = S_WB;
            S_IMM: begin
                if (instr_ack) state_next = (opcode == OP_LDI) ? S_WB : S_FETCH;
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking (<=) for all sequential state, so every register sees pre-edge values.
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            result      <= '0;
            alu_control <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            // NOTE: the register file is only four flops and must read as zero after reset,
            // so it is cleared here; a RAM-backed file would not be reset this way.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: begin
                    if (instr_ack) begin
                        ir <= instr_data;
                        pc <= pc + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (is_alu_op) begin
                        alu_control <= opcode;
                        alu_a       <= regs[rd];
                        alu_b       <= regs[rs];
                    end
                end
                S_EXEC: begin
                    result <= alu_result;
                end
                S_IMM: begin
                    if (instr_ack) begin
                        // A jump target overrides the operand-byte increment.
                        if (opcode == OP_JMP) pc <= instr_data;
                        else                  pc <= pc + 8'd1;
                        if (opcode == OP_LDI) result <= instr_data;
                    end
                end
                S_WB: begin
                    regs[rd] <= result;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and writeback strobes are forced low while reset is held.
    assign instr_req  = !rst && (state == S_FETCH || state == S_IMM);
    assign instr_addr = pc;
    assign wb_valid   = !rst && (state == S_WB);
    assign wb_addr    = rd;
    assign wb_data    = result;
    assign halted     = !rst && (state == S_HALT);

endmodule
